// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: iterative shift-add multiply, restoring divide.
// Optional macro RV_MULDIV_FAST_MUL_EN: single-step multiplies via a combinational 2*Width product.
module rv_muldiv_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] res,
  output logic             is_zero,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CntW = $clog2(Width + 1);
  localparam logic [Width-1:0] MostNeg = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]         r_op;
  logic [2*Width-1:0] r_acc;
  logic [Width-1:0]   r_b;
  logic [Width-1:0]   r_res;
  logic               r_neg;
  logic               r_neg_r;
  logic               r_is_zero;
  logic               r_dbz;
  logic [CntW-1:0]    r_cnt;

  logic               w_is_div;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [Width-1:0]   w_abs_a;
  logic [Width-1:0]   w_abs_b;
  logic               w_accept;
  logic               w_early;
  logic               w_early_dbz;
  logic [Width-1:0]   w_early_res;
  logic [Width:0]     w_mul_sum;
  logic [2*Width-1:0] w_mul_next;
  logic [Width:0]     w_rem_sh;
  logic [Width:0]     w_diff;
  logic               w_qbit;
  logic [2*Width-1:0] w_div_next;
  logic [2*Width-1:0] w_prod;
  logic [Width-1:0]   w_fix_res;

`ifdef RV_MULDIV_FAST_MUL_EN
  logic [2*Width-1:0] w_fa;
  logic [2*Width-1:0] w_fb;
  logic [2*Width-1:0] w_fprod;

  // Sign-extended operands multiplied modulo 2^(2*Width) give the exact signed/unsigned product.
  assign w_fa    = {{Width{w_a_signed & a[Width-1]}}, a};
  assign w_fb    = {{Width{w_b_signed & b[Width-1]}}, b};
  assign w_fprod = w_fa * w_fb;
`endif

  // Operand decode on the request side; only sampled when a request is accepted.
  always_comb begin
    w_is_div   = op[2];
    w_a_signed = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    w_b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    w_a_neg    = w_a_signed & a[Width-1];
    w_b_neg    = w_b_signed & b[Width-1];
    w_abs_a    = w_a_neg ? -a : a;
    w_abs_b    = w_b_neg ? -b : b;
    w_accept   = (r_state == S_IDLE) && in_valid && !flush;
  end

  always_comb begin
    w_early     = 1'b0;
    w_early_dbz = 1'b0;
    w_early_res = '0;
    if (w_is_div) begin
      if (b == '0) begin
        w_early     = 1'b1;
        w_early_dbz = 1'b1;
        w_early_res = op[1] ? a : '1;
      end else if (!op[0] && (a == MostNeg) && (b == '1)) begin
        w_early     = 1'b1;
        w_early_res = op[1] ? '0 : a;
      end
    end else begin
`ifdef RV_MULDIV_FAST_MUL_EN
      w_early     = 1'b1;
      w_early_res = (op[1:0] == 2'd0) ? w_fprod[Width-1:0] : w_fprod[2*Width-1:Width];
`else
      w_early     = (a == '0) || (b == '0);
`endif
    end
  end

  // One iteration step. r_acc holds {partial product hi, multiplier lo} or {remainder, quotient}.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*Width-1:Width]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[Width-1:1]};
    w_rem_sh   = {r_acc[2*Width-1:Width], r_acc[Width-1]};
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_qbit     = ~w_diff[Width];
    w_div_next = {(w_qbit ? w_diff[Width-1:0] : w_rem_sh[Width-1:0]), r_acc[Width-2:0], w_qbit};
  end

  always_comb begin
    w_prod    = r_neg ? -r_acc : r_acc;
    w_fix_res = '0;
    if (!r_op[2]) begin
      w_fix_res = (r_op[1:0] == 2'd0) ? w_prod[Width-1:0] : w_prod[2*Width-1:Width];
    end else if (!r_op[1]) begin
      w_fix_res = r_neg ? -r_acc[Width-1:0] : r_acc[Width-1:0];
    end else begin
      w_fix_res = r_neg_r ? -r_acc[2*Width-1:Width] : r_acc[2*Width-1:Width];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/res/flags hold until that edge, and in_ready is high only in IDLE.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_early ? S_DONE : S_BUSY;
      end
      S_BUSY:  if (r_cnt <= CntW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_is_zero <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_acc   <= {{Width{1'b0}}, w_abs_a};
            r_b     <= w_abs_b;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= w_early ? '0 : CntW'(Width);
            if (w_early) begin
              r_res     <= w_early_res;
              r_is_zero <= (w_early_res == '0);
              r_dbz     <= w_early_dbz;
            end
          end
        end
        S_BUSY: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CntW'(1);
        end
        S_FIX: begin
          r_res     <= w_fix_res;
          r_is_zero <= (w_fix_res == '0);
          r_dbz     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res         = r_res;
  assign is_zero     = r_is_zero;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: directed RV32M vectors, early-outs, backpressure, flush, reset.
module tb_rv_muldiv_unit;

  localparam int W = 32;
`ifdef RV_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         is_zero;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  rv_muldiv_unit #(.Width(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .is_zero(is_zero), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W+1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic push, input logic [W-1:0] er, input logic ez,
                       input logic ed, input int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) begin
      exp_q.push_back({er, ez, ed});
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("wait_idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_res"}, res, 32'd0);
    chk({tag, "_is_zero"}, {31'd0, is_zero}, 32'd0);
    chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // monitor
  initial begin
    logic         prev_valid;
    logic [W+1:0] held;
    logic [W+1:0] e;
    int           lat;
    int           acc;
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() == 0) begin
            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
          end else begin
            lat = lat_q.pop_front();
            acc = acc_q.pop_front();
            chk("latency", W'(cyc - acc), W'(lat));
          end
          held = {res, is_zero, div_by_zero};
        end else begin
          chk("hold_res", res, held[W+1:2]);
          chk("hold_flags", {30'd0, is_zero, div_by_zero}, {30'd0, held[1:0]});
        end
        chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("result_without_expectation", {31'd0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("res", res, e[W+1:2]);
            chk("is_zero", {31'd0, is_zero}, {31'd0, e[1]});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
          end
        end
      end
      prev_valid = rst_n && out_valid;
    end
  end

  // stimulus
  initial begin
    int t;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 3'd0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // multiply
    issue(3'd0, 32'd7,        32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0, MUL_LAT);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, MUL_LAT);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, MUL_LAT);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0, MUL_LAT);
    issue(3'd1, 32'hFFFF_FFFD, 32'd5,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, MUL_LAT);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5,        1'b1, 32'hFFFF_FFF1, 1'b0, 1'b0, MUL_LAT);
    issue(3'd0, 32'd0,        32'd5,        1'b1, 32'd0,         1'b1, 1'b0, 1);

    // divide / remainder
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, DIV_LAT);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, DIV_LAT);
    issue(3'd7, 32'd100,      32'd7,        1'b1, 32'd2,         1'b0, 1'b0, DIV_LAT);
    issue(3'd4, 32'd7,        32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, DIV_LAT);
    issue(3'd6, 32'd7,        32'hFFFF_FFFE, 1'b1, 32'd1,         1'b0, 1'b0, DIV_LAT);

    // early-out corner cases
    issue(3'd5, 32'd5,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    issue(3'd6, 32'd5,        32'd0,        1'b1, 32'd5,         1'b0, 1'b1, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,        1'b1, 1'b0, 1);

    // backpressure: hold the result for ten cycles
    wait_idle();
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 1'b0, DIV_LAT);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);

    // request coincident with flush is dropped
    wait_idle();
    flush = 1'b1;
    in_valid = 1'b1;
    op = 3'd0;
    a = 32'd3;
    b = 32'd4;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_req_dropped_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_req_dropped_state", {30'd0, dbg_state}, 32'd0);

    // flush in BUSY with counter at 10
    issue(3'd0, 32'd5, 32'd6, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    repeat (22) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, 1'b0, MUL_LAT);

    // reset in BUSY
    wait_idle();
    issue(3'd5, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_busy");
    rst_n = 1'b1;
    issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, 1'b0, DIV_LAT);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit implementing the RV32M operations; the sequential companion to the single-cycle execute ALU.
- Sits in the execute stage beside the ALU; the pipeline stalls on in_ready/out_valid.
- Multiply is iterative shift-add; divide is iterative restoring.
- Valid/ready handshakes on both sides, flush support, and an early-out for divide corner cases.

Parameters:
- Width, 32, operand/result width in bits; must be even and >= 8.
- CntW, $clog2(Width+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  abandon any in-flight op; return to IDLE next edge.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  Width  rs1 operand.
- b  in  Width  rs2 operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- res  out  Width  result.
- is_zero  out  1  res == 0.
- div_by_zero  out  1  divide/rem op with b == 0 (valid with out_valid).

Behaviour:
- Reset (rst_n low at edge): state IDLE, in_ready 1, out_valid 0, res 0, is_zero 0, div_by_zero 0, counter 0.
- States:
  - IDLE: in_ready = 1. On in_valid at an edge, latch op/a/b.
    - If a special case (below) applies, go to DONE.
    - Otherwise take absolute values per signedness and go to BUSY with counter = Width.
  - BUSY: one iteration per edge, counter decrements. When counter reaches 0, go to FIX.
  - FIX: apply sign correction (negate product/quotient/remainder as required) and select high or low half. Go to DONE.
  - DONE: out_valid = 1; res and flags stable. On out_ready at an edge, return to IDLE. A new op cannot be accepted in the same edge; in_ready is 0 in DONE.
- Latency: edges from the accepting edge to the edge that sets out_valid.
  - Normal: Width+2 (34 for Width=32).
  - Early-out: 1.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV/REM: signed.
- Results:
  - MUL returns the low Width bits of the 2*Width product; MULH* return the high Width bits.
  - Quotient truncates toward zero; remainder takes the sign of a.
- Early-out special cases (1-cycle):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give a; div_by_zero = 1.
  - Signed overflow, a = most-negative and b = -1: DIV gives a, REM gives 0, div_by_zero = 0.
  - Multiply with a == 0 or b == 0: res = 0.
- Flush:
  - Has priority over everything except reset. In any state it forces IDLE next edge and out_valid 0.
  - A request presented with flush in the same cycle is not accepted.
- Inputs a/b/op may change freely after acceptance; internal copies are used.
- out_valid held high with out_ready low: res and flags must not change.
- Reset mid-operation: identical to the reset values above; no partial result is ever presented.

Optional Feature:
- Macro: RV_MULDIV_FAST_MUL_EN
- Defined: all four multiply ops compute the full 2*Width product combinationally from the latched operands and go IDLE -> DONE with latency 1. Divide/rem are unchanged (iterative).
- Undefined: multiplies use the iterative shift-add path with latency Width+2. No wide multiplier is inferred.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> res 0xFFFFFFEB after 34 edges (1 with RV_MULDIV_FAST_MUL_EN); MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> res 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14; REMU -> 2; is_zero 0 for all.
- DIVU a=5, b=0 -> res 0xFFFFFFFF, div_by_zero 1, out_valid 1 edge after accept; REM a=5, b=0 -> res 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> res 0x80000000, 1-cycle; REM same operands -> res 0, is_zero 1.
- Backpressure: hold out_ready 0 for 10 cycles after out_valid -> res/flags stable and in_ready 0 throughout; out_ready 1 -> IDLE next edge, in_ready 1.
- Flush at BUSY counter=10 -> IDLE next edge, out_valid never asserts; next op (MUL 3*4) returns 12. rst_n low during BUSY -> all outputs at reset values next edge.
